// File: rtl/bus_memory.sv
// bus_memory: word-addressed memory that answers mem_load/mem_rd/mem_wr on the shared 32-bit bus
// and latches the first access fault. Define MEM_WRITE_PROTECT_EN to make words 0..PROTECT_WORDS-1 read-only.
module bus_memory #(
    parameter int DEPTH_WORDS   = 256,
    parameter int PROTECT_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] bus,
    input  logic        mem_load,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        fault_clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [31:0] fault_addr
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_MISALIGN = 3'd1;
    localparam logic [2:0] CODE_RANGE    = 3'd2;
    localparam logic [2:0] CODE_PROTOCOL = 3'd3;
    localparam logic [2:0] CODE_WPROT    = 3'd4;

    // state | meaning
    // IDLE  | no address latched for the next data phase
    // ARMED | mar holds an address, rdata holds its word
    typedef enum logic {IDLE, ARMED} state_t;

    state_t             state;
    logic [31:0]        mar;
    logic [31:0]        rdata;
    logic [31:0]        mem [DEPTH_WORDS];

    logic [1:0]         n_strobe;
    logic               multi;
    logic               rd_only;
    logic               wr_only;
    logic               bus_ok;
    logic               mar_ok;
    logic [ADDR_W-1:0]  bus_idx;
    logic [ADDR_W-1:0]  mar_idx;
    logic               wr_protected;
    logic               do_write;
    logic [2:0]         new_code;
    logic [31:0]        new_addr;

    assign n_strobe = {1'b0, mem_load} + {1'b0, mem_rd} + {1'b0, mem_wr};
    assign multi    = (n_strobe > 2'd1);
    assign rd_only  = mem_rd & ~mem_load & ~mem_wr;
    assign wr_only  = mem_wr & ~mem_load & ~mem_rd;

    assign bus_idx  = bus[ADDR_W+1:2];
    assign mar_idx  = mar[ADDR_W+1:2];
    assign bus_ok   = (bus[1:0] == 2'b00) && (bus[31:ADDR_W+2] == '0);
    assign mar_ok   = (mar[1:0] == 2'b00) && (mar[31:ADDR_W+2] == '0);

`ifdef MEM_WRITE_PROTECT_EN
    assign wr_protected = mar_ok && (32'(mar_idx) < 32'(PROTECT_WORDS));
`else
    logic unused_protect;
    assign unused_protect = (PROTECT_WORDS != 0);
    assign wr_protected   = 1'b0;
`endif

    assign do_write = wr_only && (state == ARMED) && mar_ok && !wr_protected;

    // Reset releases the bus asynchronously, even mid-read.
    assign bus = (rd_only && !rst) ? rdata : 'z;

    always_comb begin
        new_code = CODE_NONE;
        new_addr = mar;
        if (multi) begin
            new_code = CODE_PROTOCOL;
            if (mem_load) new_addr = bus;
        end else if (mem_load) begin
            new_addr = bus;
            if (bus[1:0] != 2'b00)
                new_code = CODE_MISALIGN;
            else if (bus[31:ADDR_W+2] != '0)
                new_code = CODE_RANGE;
        end else if ((mem_rd || mem_wr) && (state == IDLE)) begin
            new_code = CODE_PROTOCOL;
        end else if (wr_only && wr_protected) begin
            new_code = CODE_WPROT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mar        <= '0;
            rdata      <= '0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            fault_addr <= '0;
        end else begin
            if (mem_load) begin
                mar   <= bus;
                rdata <= bus_ok ? mem[bus_idx] : '0;
                state <= ARMED;
            end else begin
                if (do_write) rdata <= bus;
                if (mem_rd || mem_wr) state <= IDLE;
            end

            // A fault arriving with fault_clr is captured rather than cleared.
            if ((new_code != CODE_NONE) && (!fault || fault_clr)) begin
                fault      <= 1'b1;
                fault_code <= new_code;
                fault_addr <= new_addr;
            end else if (fault_clr) begin
                fault      <= 1'b0;
                fault_code <= CODE_NONE;
                fault_addr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[mar_idx] <= bus;
    end

endmodule

// File: tb/tb_bus_memory.sv
// Self-checking bench for bus_memory: transaction-level model compared every cycle plus directed literal checks.
// Honours MEM_WRITE_PROTECT_EN the same way as the design.
module tb_bus_memory;
    localparam int          DEPTH    = 256;
    localparam int          PROT     = 16;
    localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_load = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, fault_clr = 1'b0;
    logic        tb_drive = 1'b0;
    logic [31:0] tb_val = '0;
    wire  [31:0] bus;
    logic        fault;
    logic [2:0]  fault_code;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    // Undriven bus floats high so a released bus is observable.
    pullup (bus);
    assign bus = tb_drive ? tb_val : 'z;

    bus_memory #(.DEPTH_WORDS(DEPTH), .PROTECT_WORDS(PROT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_load(mem_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .fault_clr(fault_clr),
        .fault(fault), .fault_code(fault_code), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_mar = '0, m_rdata = '0, m_faddr = '0;
    bit          m_rknown = 1'b1, m_armed = 1'b0, m_fault = 1'b0;
    int          m_code = 0;

    function automatic bit word_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    function automatic bit is_protected(input logic [31:0] a);
`ifdef MEM_WRITE_PROTECT_EN
        return word_ok(a) && ((a / 4) < PROT);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        int          n;
        int          code;
        logic [31:0] addr;
        if (rst) begin
            m_mar = '0; m_rdata = '0; m_rknown = 1'b1; m_armed = 1'b0;
            m_fault = 1'b0; m_code = 0; m_faddr = '0;
        end else begin
            n    = int'(mem_load) + int'(mem_rd) + int'(mem_wr);
            code = 0;
            addr = m_mar;
            if (n > 1) begin
                code = 3;
                if (mem_load) addr = tb_val;
            end else if (mem_load) begin
                addr = tb_val;
                if (tb_val % 4 != 0)          code = 1;
                else if (tb_val >= DEPTH * 4) code = 2;
            end else if ((mem_rd || mem_wr) && !m_armed) begin
                code = 3;
            end else if (mem_wr && is_protected(m_mar)) begin
                code = 4;
            end

            if (mem_load) begin
                m_mar = tb_val;
                if (word_ok(tb_val)) begin
                    m_rdata  = m_mem[tb_val / 4];
                    m_rknown = m_known[tb_val / 4];
                end else begin
                    m_rdata  = '0;
                    m_rknown = 1'b1;
                end
                m_armed = 1'b1;
            end else if (n >= 1) begin
                if (n == 1 && mem_wr && m_armed && word_ok(m_mar) && !is_protected(m_mar)) begin
                    m_mem[m_mar / 4]   = tb_val;
                    m_known[m_mar / 4] = 1'b1;
                    m_rdata  = tb_val;
                    m_rknown = 1'b1;
                end
                m_armed = 1'b0;
            end

            if (code != 0 && (!m_fault || fault_clr)) begin
                m_fault = 1'b1; m_code = code; m_faddr = addr;
            end else if (fault_clr) begin
                m_fault = 1'b0; m_code = 0; m_faddr = '0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_fault", fault, m_fault);
        chk("model_code", fault_code, 32'(m_code));
        chk("model_faddr", fault_addr, m_faddr);
        if (!tb_drive) begin
            if (mem_rd && !mem_load && !mem_wr && !rst) begin
                if (m_rknown) chk("model_bus_rd", bus, m_rdata);
            end else begin
                chk("model_bus_rel", bus, RELEASED);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit l, input bit r, input bit w, input bit c, input logic [31:0] d);
        mem_load = l; mem_rd = r; mem_wr = w; fault_clr = c;
        tb_drive = l | w;
        tb_val   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, '0);
    endtask

    task automatic do_load(input logic [31:0] a);
        drive(1, 0, 0, 0, a); tick();
    endtask

    task automatic do_wr(input logic [31:0] d);
        drive(0, 0, 1, 0, d); tick();
    endtask

    task automatic do_clr();
        drive(0, 0, 0, 1, '0); tick();
    endtask

    task automatic do_rd_check(input string name, input logic [31:0] exp);
        drive(0, 1, 0, 0, '0);
        @(negedge clk);
        #1;
        chk(name, bus, exp);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 0, 0, 0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_fault", fault, 1'b0);
        chk("rst_code", fault_code, 3'd0);
        chk("rst_faddr", fault_addr, 32'h0);
        chk("rst_bus", bus, RELEASED);

        // read with no address phase: stale reset rdata, protocol fault
        do_rd_check("rd_noload_bus", 32'h0);
        chk("rd_noload_code", fault_code, 3'd3);
        chk("rd_noload_faddr", fault_addr, 32'h0);
        do_clr();
        chk("clr_fault", fault, 1'b0);

        // write then read back
        do_load(32'h40); do_wr(32'hDEAD_BEEF);
        do_load(32'h40); do_rd_check("wr_rd_bus", 32'hDEAD_BEEF);
        chk("wr_rd_fault", fault, 1'b0);

        // fetch timing and ARMED holding through idle cycles
        do_load(32'h44); do_wr(32'h0BAD_F00D);
        do_load(32'h44); do_rd_check("fetch_bus", 32'h0BAD_F00D);
        do_load(32'h44); tick(); tick();
        do_rd_check("armed_hold_bus", 32'h0BAD_F00D);
        chk("armed_hold_fault", fault, 1'b0);

        // last word of the array
        do_load(32'h3FC); do_wr(32'hA5A5_5A5A);
        do_load(32'h3FC); do_rd_check("last_word_bus", 32'hA5A5_5A5A);
        chk("last_word_fault", fault, 1'b0);

        // misaligned, sticky, then out of range
        do_load(32'h42);
        chk("misal_code", fault_code, 3'd1);
        chk("misal_faddr", fault_addr, 32'h42);
        do_rd_check("misal_bus", 32'h0);
        do_load(32'h1_0000);
        chk("sticky_code", fault_code, 3'd1);
        do_clr();
        do_load(32'h1_0000);
        chk("range_code", fault_code, 3'd2);
        chk("range_faddr", fault_addr, 32'h1_0000);
        do_clr();
        do_load(32'h400);
        chk("range_edge_code", fault_code, 3'd2);

        // load+rd together with fault_clr: new protocol fault beats the clear
        drive(1, 1, 0, 1, 32'h40); tick();
        chk("multi_code", fault_code, 3'd3);
        chk("multi_faddr", fault_addr, 32'h40);
        do_rd_check("after_multi_bus", 32'hDEAD_BEEF);
        chk("after_multi_code", fault_code, 3'd3);
        do_clr();

        // reset between load and write: write never commits
        do_load(32'h80); do_wr(32'hCAFE_0080);
        do_load(32'h80);
        drive(0, 0, 1, 0, 32'h1234);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, '0);
        do_wr(32'h1234);
        chk("wr_after_rst_code", fault_code, 3'd3);
        chk("wr_after_rst_faddr", fault_addr, 32'h0);
        do_clr();
        do_load(32'h80); do_rd_check("rst_nocommit_bus", 32'hCAFE_0080);

        // reset during a read releases the bus at once
        do_load(32'h80);
        drive(0, 1, 0, 0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_release_bus", bus, RELEASED);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, '0);
        tick();

        // low-word write: protected or not depending on build
        do_load(32'h08); do_wr(32'h5555);
`ifdef MEM_WRITE_PROTECT_EN
        chk("wp_code", fault_code, 3'd4);
        chk("wp_faddr", fault_addr, 32'h08);
        do_load(32'h08);
        drive(0, 1, 0, 0, '0);
        @(negedge clk);
        #1;
        checks++;
        if (bus === 32'h5555) begin
            errors++;
            $display("FAIL wp_unchanged: got %h, required anything but 00005555", bus);
        end
        tick();
`else
        chk("nowp_fault", fault, 1'b0);
        do_load(32'h08); do_rd_check("nowp_bus", 32'h5555);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_memory.md
Name: bus_memory

Overview:
Word-addressed data/instruction memory that responds to the control unit's memory strobes (mem_load, mem_rd, mem_wr) on the shared 32-bit tri-state bus. It is the responder side of the bus protocol: it latches an address, returns read data, and commits write data, with the sequencing the control unit uses for instruction fetch, LW and SW. It also checks each access and records the first protocol or addressing fault for debug.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two, minimum 4
PROTECT_WORDS, 16, words 0..PROTECT_WORDS-1 are read-only; used only when MEM_WRITE_PROTECT_EN is defined

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
bus  inout  32  shared system bus; driven only while a read is being served, otherwise 'z
mem_load  input  1  address phase: bus carries the byte address
mem_rd  input  1  read data phase: memory drives the bus
mem_wr  input  1  write data phase: bus carries the write data
fault_clr  input  1  clears a sticky fault; synchronous
fault  output  1  sticky fault flag
fault_code  output  3  0 none, 1 misaligned, 2 out of range, 3 protocol, 4 write-protect
fault_addr  output  32  address (mar) latched when the first fault occurred

Behaviour:
- Reset (async, rst=1): mar=0, rdata=0, state=IDLE, fault=0, fault_code=0, fault_addr=0, bus released ('z). Array contents are not reset.
- Word index is mar[ADDR_W+1:2], where ADDR_W=$clog2(DEPTH_WORDS). An address is valid only if addr[1:0]==0 and addr[31:ADDR_W+2]==0.
- Address phase: at a posedge with mem_load=1, mar<=bus. At the same edge, rdata<=array[bus index] if the address is valid, else rdata<=0. Read data is therefore valid from that edge, half a cycle before the control unit's next-phase capture edge.
- Read phase: bus=rdata combinationally while mem_rd=1, mem_load=0 and mem_wr=0. Otherwise bus='z. The bus is never driven during mem_load or mem_wr.
- Write phase: at a posedge with mem_wr=1 (and mem_load=0, mem_rd=0) in state ARMED with a valid mar, array[mar index]<=bus and rdata<=bus, so a following read returns the new value. Writes with an invalid mar are dropped.
- State machine:
  - IDLE: mem_load -> ARMED. mem_rd or mem_wr alone -> protocol fault (code 3); the read still drives the bus with stale rdata, the write is dropped.
  - ARMED: mem_rd or mem_wr -> IDLE after the access. mem_load -> ARMED with the new address; re-addressing is legal. No strobes -> stay in ARMED.
- Simultaneous strobes: any two of mem_load/mem_rd/mem_wr in one cycle -> protocol fault. mem_load still latches the address, no write occurs, and the bus is not driven. Resulting state is ARMED if mem_load was set, else IDLE.
- Fault capture: when a fault occurs and fault=0, set fault=1, fault_code and fault_addr (bus value if the fault arises on mem_load, else mar). Later faults do not overwrite until cleared.
  - Misaligned (1) and out of range (2) are detected at mem_load; misaligned takes priority.
  - fault_clr=1 at a posedge clears fault, fault_code and fault_addr. A new fault in the same cycle wins over the clear.
- Reset mid-access: state returns to IDLE and the bus is released immediately (asynchronously). A partially sequenced write never commits.

Optional Feature:
MEM_WRITE_PROTECT_EN
- Defined: a write to word index < PROTECT_WORDS is dropped (array and rdata unchanged) and raises fault code 4. State still returns to IDLE.
- Not defined: all valid addresses are writable, PROTECT_WORDS is ignored, and code 4 never appears.

Test Plan:
- Write then read: load 0x0000_0040, wr 0xDEAD_BEEF, load 0x40, rd -> bus=0xDEADBEEF during rd, fault=0.
- Fetch timing: load 0x44 at edge N, rd in the following phase -> bus valid before edge N+1, value = array[17]; bus='z in all other phases.
- Misaligned load 0x0000_0042 then rd -> bus=0, fault=1, code=1, fault_addr=0x42. A later load 0x1_0000 leaves code=1; after fault_clr then load 0x1_0000 -> code=2.
- rd with no preceding load from reset -> bus=0 (reset rdata), fault_code=3; load+rd asserted in the same cycle -> bus stays 'z, code=3 (after clear).
- rst asserted between load 0x80 and wr 0x1234 -> bus='z, state IDLE, array[32] unchanged; a subsequent wr without load -> code=3.
- MEM_WRITE_PROTECT_EN defined: load 0x08, wr 0x5555 -> array[2] unchanged, code=4. Without the macro, the same sequence writes 0x5555 and fault=0.
